// File: rtl/read_burst_ctrl.sv
// Burst read sequencer: issues base/length commanded reads to a 256-entry synchronous
// memory and streams the returned words through a 2-entry buffer. Optional: BURST_LOOP_EN.
module read_burst_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        base_addr,
    input  logic [7:0]        burst_len,
    input  logic              loop,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [7:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    if (MEM_LAT != 1) begin : g_bad_mem_lat
        $error("read_burst_ctrl: only MEM_LAT=1 is supported");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [8:0]        remaining, remaining_nxt;
    logic [7:0]        addr_nxt;
    logic [8:0]        start_len;
    logic              issue;
    logic              done_nxt;
    logic              rd_vld_p1;
    logic [DATA_W-1:0] buf_data [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        buf_cnt;
    logic              pop;
    logic              drained;
    logic [2:0]        occupancy;

`ifdef BURST_LOOP_EN
    logic [7:0]        base_q;
    logic [8:0]        len_q;
    logic              loop_q;
    logic              abort_seen;
`else
    logic              unused_loop;
    assign unused_loop = loop;
`endif

    assign start_len = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign drained   = !rd_vld_p1 && (buf_cnt == 2'd0);
    assign busy      = (state != IDLE);
    assign mem_rd_en = issue;

    // Slots still claimed at the next edge: the word in flight plus what the buffer
    // keeps after this cycle's pop. Counting the pop keeps 1 word/cycle streaming.
    assign occupancy = {2'b00, rd_vld_p1} + {1'b0, buf_cnt} - {2'b00, pop};

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        addr_nxt      = mem_addr;
        issue         = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    addr_nxt      = base_addr;
                    remaining_nxt = start_len;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = DRAIN;
                end else if ((remaining != 9'd0) && (occupancy < 3'd2)) begin
                    issue         = 1'b1;
                    remaining_nxt = remaining - 9'd1;
                    addr_nxt      = mem_addr + 8'd1;
                    if (remaining == 9'd1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
`ifdef BURST_LOOP_EN
                    if (loop_q && !abort_seen && !abort) begin
                        state_nxt     = RUN;
                        remaining_nxt = len_q;
                        addr_nxt      = base_q;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 9'd0;
            mem_addr  <= 8'd0;
            rd_vld_p1 <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            mem_addr  <= addr_nxt;
            rd_vld_p1 <= issue;
            done      <= done_nxt;
        end
    end

    // Output buffer: memory data lands here the cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            if (rd_vld_p1) begin
                buf_data[wr_ptr] <= mem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({rd_vld_p1, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

`ifdef BURST_LOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= 8'd0;
            len_q      <= 9'd0;
            loop_q     <= 1'b0;
            abort_seen <= 1'b0;
        end else if (state == IDLE) begin
            abort_seen <= 1'b0;
            if (start) begin
                base_q <= base_addr;
                len_q  <= start_len;
                loop_q <= loop;
            end
        end else if (abort) begin
            abort_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_read_burst_ctrl.sv
// Self-checking bench for read_burst_ctrl: randomized bursts against a queue-based
// reference (address i = base + i mod 256, data = memory image at that address).
module tb_read_burst_ctrl;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        base_addr = 8'd0;
    logic [7:0]        burst_len = 8'd0;
    logic              loop = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic              mem_rd_en;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [256];
    logic [7:0]        iss_q [$];
    int                iss_cyc_q [$];
    logic [DATA_W-1:0] out_q [$];
    int                done_cnt = 0;
    int                max_occ = 0;
    int                stab_err = 0;
    int                cyc = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    read_burst_ctrl #(.DATA_W(DATA_W), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .loop(loop), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Observer: records reads, deliveries, done pulses, occupancy and stall stability
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (iss_q.size() - out_q.size() > max_occ) max_occ = iss_q.size() - out_q.size();
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err = stab_err + 1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (mem_rd_en) begin
                iss_q.push_back(mem_addr);
                iss_cyc_q.push_back(cyc);
            end
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (done) done_cnt = done_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iss_q.delete();
        iss_cyc_q.delete();
        out_q.delete();
        done_cnt = 0;
        max_occ  = 0;
        stab_err = 0;
    endtask

    task automatic kick(input logic [7:0] b, input logic [7:0] l, input logic lp);
        base_addr = b;
        burst_len = l;
        loop      = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_idle(input int budget, input int rdy_pct, input int stall_at,
                            input int stall_n, output bit to);
        int i;
        i  = 0;
        to = 1'b1;
        while (i < budget) begin
            if (i >= stall_at && i < stall_at + stall_n) out_ready = 1'b0;
            else out_ready = (int'($urandom_range(99)) < rdy_pct);
            tick();
            i++;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
        tick();
    endtask

    function automatic bit addr_bad(input int base, input int len, input int n);
        addr_bad = (iss_q.size() != n);
        for (int i = 0; i < iss_q.size() && i < n; i++)
            if (int'(iss_q[i]) != (base + i % len) % 256) addr_bad = 1'b1;
    endfunction

    function automatic bit data_bad(input int base, input int len, input int n);
        data_bad = (out_q.size() != n);
        for (int i = 0; i < out_q.size() && i < n; i++)
            if (out_q[i] !== mem[8'((base + i % len) % 256)]) data_bad = 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({mem_rd_en, out_valid, busy, done} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got rd_en/valid/busy/done=%b, want 0000", {mem_rd_en, out_valid, busy, done});
        end
        tests++;
        if (mem_addr !== 8'd0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h data=%h, want 0/0", mem_addr, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        int lat;
        clr();
        out_ready = 1'b1;
        kick(8'h10, 8'd4, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy_rise: got %b, want 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles, want 2", lat);
        end
        run_idle(50, 100, 0, 0, to);
        tests++;
        if (to !== 1'b0 || addr_bad(8'h10, 4, 4) || data_bad(8'h10, 4, 4)) begin
            fails++;
            $display("FAIL basic_seq: got timeout=%b reads=%0d words=%0d, want 0/4/4 in order", to, iss_q.size(), out_q.size());
        end
        tests++;
        if (iss_cyc_q.size() != 4 || iss_cyc_q[3] - iss_cyc_q[0] != 3) begin
            fails++;
            $display("FAIL basic_back_to_back: got %0d reads not on consecutive cycles, want 4 consecutive", iss_cyc_q.size());
        end
        tests++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: got done=%0d busy=%b, want 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        bit to;
        clr();
        out_ready = 1'b0;
        kick(8'hFE, 8'd4, 1'b0);
        run_idle(200, 60, 0, 0, to);
        tests++;
        if (to !== 1'b0 || addr_bad(8'hFE, 4, 4) || data_bad(8'hFE, 4, 4) || done_cnt !== 1) begin
            fails++;
            $display("FAIL wrap_seq: got reads=%0d first=%h words=%0d done=%0d, want 4 from fe, 4, 1", iss_q.size(), iss_q.size() > 0 ? iss_q[0] : 8'h0, out_q.size(), done_cnt);
        end
    endtask

    task automatic test_len0();
        bit to;
        logic [7:0] b;
        b = 8'($urandom);
        clr();
        out_ready = 1'b1;
        kick(b, 8'd0, 1'b0);
        run_idle(400, 100, 0, 0, to);
        tests++;
        if (to !== 1'b0 || addr_bad(b, 256, 256) || data_bad(b, 256, 256)) begin
            fails++;
            $display("FAIL len0_seq: got reads=%0d words=%0d, want 256/256 covering all addresses", iss_q.size(), out_q.size());
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL len0_done: got %0d pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_stall();
        bit to;
        clr();
        out_ready = 1'b1;
        kick(8'h00, 8'd8, 1'b0);
        run_idle(100, 100, 2, 5, to);
        tests++;
        if (to !== 1'b0 || addr_bad(0, 8, 8) || data_bad(0, 8, 8)) begin
            fails++;
            $display("FAIL stall_seq: got reads=%0d words=%0d, want 8/8 no loss or duplicate", iss_q.size(), out_q.size());
        end
        tests++;
        if (max_occ > 2) begin
            fails++;
            $display("FAIL stall_occupancy: got %0d outstanding, want at most 2", max_occ);
        end
        tests++;
        if (stab_err !== 0) begin
            fails++;
            $display("FAIL stall_stable: got %0d data changes while stalled, want 0", stab_err);
        end
    endtask

    task automatic test_abort();
        bit to;
        int k;
        logic [7:0] b;
        b = 8'($urandom);
        clr();
        out_ready = 1'b1;
        kick(b, 8'd10, 1'b0);
        k = 0;
        while (iss_q.size() < 3 && k < 20) begin
            tick();
            k++;
        end
        abort     = 1'b1;
        out_ready = 1'b0;
        tick();
        abort = 1'b0;
        repeat (5) tick();
        tests++;
        if (iss_q.size() !== 3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_stop: got reads=%0d busy=%b, want 3/1", iss_q.size(), busy);
        end
        run_idle(50, 100, 0, 0, to);
        tests++;
        if (to !== 1'b0 || data_bad(b, 10, 3)) begin
            fails++;
            $display("FAIL abort_deliver: got words=%0d, want 3 in order", out_q.size());
        end
        tests++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: got done=%0d busy=%b, want 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_start_abort();
        bit to;
        clr();
        out_ready = 1'b1;
        abort = 1'b1;
        kick(8'h55, 8'd4, 1'b0);
        tick();
        abort = 1'b0;
        run_idle(20, 100, 0, 0, to);
        tests++;
        if (to !== 1'b0 || iss_q.size() !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL start_abort: got reads=%0d done=%0d busy=%b, want 0/1/0", iss_q.size(), done_cnt, busy);
        end
    endtask

    task automatic test_ignored();
        bit to;
        clr();
        out_ready = 1'b0;
        kick(8'h20, 8'd6, 1'b0);
        tick();
        kick(8'h80, 8'd5, 1'b0);
        run_idle(200, 50, 0, 0, to);
        tests++;
        if (to !== 1'b0 || addr_bad(8'h20, 6, 6) || data_bad(8'h20, 6, 6) || done_cnt !== 1) begin
            fails++;
            $display("FAIL start_while_busy: got reads=%0d words=%0d done=%0d, want 6/6/1 from 20", iss_q.size(), out_q.size(), done_cnt);
        end
        clr();
        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        tick();
        tests++;
        if (iss_q.size() !== 0 || busy !== 1'b0 || done_cnt !== 0) begin
            fails++;
            $display("FAIL abort_in_idle: got reads=%0d busy=%b done=%0d, want 0/0/0", iss_q.size(), busy, done_cnt);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [7:0] b;
        int n;
        int pct;
        for (int it = 0; it < 8; it++) begin
            b   = 8'($urandom);
            n   = int'($urandom_range(1, 40));
            pct = int'($urandom_range(30, 100));
            clr();
            out_ready = 1'b0;
            kick(b, 8'(n), 1'b0);
            run_idle(2000, pct, 0, 0, to);
            tests++;
            if (to !== 1'b0 || addr_bad(b, n, n) || data_bad(b, n, n)) begin
                fails++;
                $display("FAIL rand_seq[%0d]: got reads=%0d words=%0d, want %0d from %h", it, iss_q.size(), out_q.size(), n, b);
            end
            tests++;
            if (done_cnt !== 1 || max_occ > 2 || stab_err !== 0) begin
                fails++;
                $display("FAIL rand_ctrl[%0d]: got done=%0d occ=%0d unstable=%0d, want 1/<=2/0", it, done_cnt, max_occ, stab_err);
            end
        end
    endtask

    task automatic test_loop();
        bit to;
        clr();
        out_ready = 1'b1;
`ifdef BURST_LOOP_EN
        begin
            int k;
            int busy_low;
            kick(8'h40, 8'd2, 1'b1);
            k = 0;
            busy_low = 0;
            while (done_cnt < 3 && k < 100) begin
                tick();
                k++;
                if (!busy) busy_low++;
            end
            tests++;
            if (done_cnt !== 3 || busy_low !== 0) begin
                fails++;
                $display("FAIL loop_passes: got done=%0d busy_low=%0d, want 3/0", done_cnt, busy_low);
            end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            run_idle(50, 100, 0, 0, to);
            tests++;
            if (to !== 1'b0 || iss_q.size() < 6 || iss_q.size() > 8 ||
                addr_bad(8'h40, 2, iss_q.size()) || data_bad(8'h40, 2, iss_q.size())) begin
                fails++;
                $display("FAIL loop_seq: got reads=%0d words=%0d, want 6..8 repeating 40,41", iss_q.size(), out_q.size());
            end
            tests++;
            if (done_cnt !== 4 || busy !== 1'b0) begin
                fails++;
                $display("FAIL loop_abort_end: got done=%0d busy=%b, want 4/0", done_cnt, busy);
            end
        end
`else
        kick(8'h40, 8'd2, 1'b1);
        run_idle(50, 100, 0, 0, to);
        tests++;
        if (to !== 1'b0 || addr_bad(8'h40, 2, 2) || data_bad(8'h40, 2, 2)) begin
            fails++;
            $display("FAIL loop_ignored_seq: got reads=%0d words=%0d, want 2/2", iss_q.size(), out_q.size());
        end
        tests++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL loop_ignored_done: got done=%0d busy=%b, want 1/0", done_cnt, busy);
        end
`endif
        loop = 1'b0;
    endtask

    task automatic test_reset_mid();
        clr();
        out_ready = 1'b0;
        kick(8'h33, 8'd20, 1'b0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_rd_en, out_valid, busy, done} !== 4'b0 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_clear: got rd_en/valid/busy/done=%b addr=%h, want 0000/00", {mem_rd_en, out_valid, busy, done}, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        clr();
        out_ready = 1'b1;
        repeat (5) tick();
        tests++;
        if (iss_q.size() !== 0 || out_q.size() !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after: got reads=%0d words=%0d done=%0d busy=%b, want 0/0/0/0", iss_q.size(), out_q.size(), done_cnt, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_wrap();
        test_len0();
        test_stall();
        test_abort();
        test_start_abort();
        test_ignored();
        test_random();
        test_loop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
